vfp_addsub_sequencer: RTL
=========================

VFP_ADDSUB_SEQUENCER -- requirements
Module: vfp_addsub_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning maximum cycles to wait for unit_done_i per beat.
REQ-002 SHALL have parameter VL_W, default 7, meaning the width of the vector-length field.
REQ-003 SHALL have port clk_i  input  1  the single clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  command present.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-007 SHALL have port cmd_sub_i  input  1  0 selects add, 1 selects subtract.
REQ-008 SHALL have port cmd_vsew_i  input  2  2'b10 selects 32-bit elements, 2'b11 selects 64-bit elements.
REQ-009 SHALL have port cmd_vl_i  input  VL_W  element count.
REQ-010 SHALL have port opd_valid_i / opd_ready_o  input/output  1/1  operand beat handshake.
REQ-011 SHALL have port opd_vs1_i, opd_vs2_i  input  128 each  operand beat, element 0 in the least-significant lane.
REQ-012 SHALL have port add_sub_o  output  1  to the add/sub unit.
REQ-013 SHALL have port vsew_o  output  2  to the add/sub unit.
REQ-014 SHALL have port vs1_o, vs2_o  output  128 each  to the add/sub unit.
REQ-015 SHALL have port unit_done_i  input  1  unit result-ready pulse.
REQ-016 SHALL have port unit_vd_i  input  128  unit result.
REQ-017 SHALL have port res_valid_o / res_ready_i  output/input  1/1  result beat handshake.
REQ-018 SHALL have port res_data_o  output  128  result beat.
REQ-019 SHALL have port cmd_done_o  output  1  one-cycle pulse at command completion.
REQ-020 SHALL have port cmd_err_o  output  1  valid with cmd_done_o; 1 means illegal vsew or timeout.

Function
REQ-021 SHALL implement the states IDLE, FETCH, ISSUE, GAP, OUT and DONE.
REQ-022 IDLE: cmd_ready_o=1; on handshake, latch sub/vsew/vl, set beat element index to 0, go to FETCH.
REQ-023 SHALL set elements per beat (EPB) to 4 when vsew=10 and 2 when vsew=11.
REQ-024 SHALL make the beat count ceil(vl/EPB).
REQ-025 vsew 00/01 at acceptance: no beats; go to DONE with cmd_err_o=1.
REQ-026 vl=0 at acceptance: no beats; go to DONE with cmd_err_o=0.
REQ-027 FETCH: opd_ready_o=1; on handshake, register operands with lanes at index>=remaining elements forced to zero, then go to ISSUE.
REQ-028 ISSUE: drive add_sub_o=sub, vsew_o=latched vsew and the registered vs1_o/vs2_o, all stable until exit; the watchdog counter starts at 0.
REQ-029 ISSUE exit on unit_done_i=1: capture unit_vd_i with tail lanes zeroed into the result register, go to GAP.
REQ-030 ISSUE timeout when the counter reaches TIMEOUT with no unit_done_i: go to DONE with cmd_err_o=1; remaining operand beats are not consumed.
REQ-031 Outside ISSUE: vsew_o=2'b00, add_sub_o=0, vs1_o=vs2_o=0, so the unit sees no operation; GAP lasts exactly 1 cycle, then OUT.
REQ-032 OUT: res_valid_o=1 with res_data_o held until res_ready_i.
REQ-033 OUT on handshake: advance the element index by EPB; go to DONE if it was the last beat, else FETCH.
REQ-034 DONE: cmd_done_o=1 for exactly 1 cycle, then IDLE; cmd_err_o is cleared on the following cycle.
REQ-035 SHALL leave cmd_ready_o, opd_ready_o and res_valid_o mutually exclusive and asserted only in their own states.
REQ-036 SHALL add 1 cycle from opd handshake to unit drive, plus 1 GAP cycle, plus the unit latency to res_valid_o.
REQ-037 SHALL ignore unit_done_i outside ISSUE.

Reset
REQ-038 rst_ni low: state=IDLE; every output 0 except cmd_ready_o=1 after release; counters, index and latched fields cleared.
REQ-039 Reset mid-command: abandon the command with no cmd_done_o pulse.

Verification
REQ-040 add, vsew=10, vl=4, vs1 lanes 1.0f, vs2 lanes 2.0f, done after 3 cycles -> one result beat of 0x40400000 x4, cmd_done_o=1, cmd_err_o=0.
REQ-041 sub, vsew=11, vl=3 -> 2 beats; beat 2 upper operand lane driven 0 and res_data_o[127:64]=0; vsew_o=00 for 1 cycle between beats.
REQ-042 vsew=01 command -> cmd_done_o pulse 2 cycles after acceptance with cmd_err_o=1; opd_ready_o never asserted.
REQ-043 unit_done_i withheld, TIMEOUT=15 -> cmd_done_o with cmd_err_o=1 exactly 16 cycles after ISSUE entry; vsew_o returns to 00.
REQ-044 res_ready_i low for 5 cycles in OUT -> res_data_o stable and no new opd handshake; rst_ni pulse during ISSUE -> all outputs 0 and no cmd_done_o.

Source files
------------

// File: rtl/vfp_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// vfp_addsub_sequencer
//
// Splits a vector add/subtract command into 128-bit operand beats, drives each
// beat into an external floating-point add/sub unit, waits (with a watchdog)
// for the unit's result and hands the result beat downstream. Elements past
// the vector length are zeroed both on the way in and on the way out.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_sub_i, cmd_vsew_i, cmd_vl_i  add/sub select, element width, length
//   opd_valid_i / opd_ready_o      operand beat handshake
//   opd_vs1_i, opd_vs2_i           operand beat, element 0 in the low lane
//   add_sub_o, vsew_o, vs1_o, vs2_o  operation presented to the unit
//   unit_done_i, unit_vd_i         unit result-ready pulse and result
//   res_valid_o / res_ready_i      result beat handshake
//   res_data_o                     result beat
//   cmd_done_o, cmd_err_o          completion pulse and error flag
// ---------------------------------------------------------------------------
module vfp_addsub_sequencer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned VL_W    = 7
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_sub_i,
    input  logic [1:0]      cmd_vsew_i,
    input  logic [VL_W-1:0] cmd_vl_i,
    input  logic            opd_valid_i,
    output logic            opd_ready_o,
    input  logic [127:0]    opd_vs1_i,
    input  logic [127:0]    opd_vs2_i,
    output logic            add_sub_o,
    output logic [1:0]      vsew_o,
    output logic [127:0]    vs1_o,
    output logic [127:0]    vs2_o,
    input  logic            unit_done_i,
    input  logic [127:0]    unit_vd_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [127:0]    res_data_o,
    output logic            cmd_done_o,
    output logic            cmd_err_o
);

    localparam int unsigned WD_W  = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
    // One extra bit so the element index can step past the largest vl.
    localparam int unsigned IDX_W = VL_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_GAP,
        S_OUT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              sub_q,   sub_d;
    logic [1:0]        vsew_q,  vsew_d;
    logic [VL_W-1:0]   vl_q,    vl_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [WD_W-1:0]   wdog_q,  wdog_d;
    logic              err_q,   err_d;
    logic [127:0]      vs1_q,   vs1_d;
    logic [127:0]      vs2_q,   vs2_d;
    logic [127:0]      res_q,   res_d;

    logic [IDX_W-1:0]  epb;
    logic [IDX_W-1:0]  vl_ext;
    logic              beats_left;
    logic              last_beat;
    logic [3:0]        lane_keep;
    logic [127:0]      keep_mask;

    assign vl_ext     = {1'b0, vl_q};
    assign epb        = vsew_q[0] ? IDX_W'(2) : IDX_W'(4);
    assign beats_left = idx_q < vl_ext;
    assign last_beat  = (idx_q + epb) >= vl_ext;

    // Per 32-bit slot: keep it only if the element it belongs to is below vl.
    // With 64-bit elements two adjacent slots share one element.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            lane_keep[j]          = (idx_q + (vsew_q[0] ? IDX_W'(j / 2) : IDX_W'(j))) < vl_ext;
            keep_mask[32*j +: 32] = {32{lane_keep[j]}};
        end
    end

    // NOTE: every signal written below gets its default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        vsew_d      = vsew_q;
        vl_d        = vl_q;
        idx_d       = idx_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        vs1_d       = vs1_q;
        vs2_d       = vs2_q;
        res_d       = res_q;

        cmd_ready_o = 1'b0;
        opd_ready_o = 1'b0;
        add_sub_o   = 1'b0;
        vsew_o      = 2'b00;
        vs1_o       = '0;
        vs2_o       = '0;
        res_valid_o = 1'b0;
        res_data_o  = '0;
        cmd_done_o  = 1'b0;
        cmd_err_o   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    sub_d   = cmd_sub_i;
                    vsew_d  = cmd_vsew_i;
                    vl_d    = cmd_vl_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end

            // Illegal width and empty vectors are resolved here rather than
            // in IDLE, so they finish without ever raising opd_ready_o.
            S_FETCH: begin
                if (!vsew_q[1]) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!beats_left) begin
                    state_d = S_DONE;
                end else begin
                    opd_ready_o = 1'b1;
                    if (opd_valid_i) begin
                        vs1_d   = opd_vs1_i & keep_mask;
                        vs2_d   = opd_vs2_i & keep_mask;
                        wdog_d  = '0;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                add_sub_o = sub_q;
                vsew_o    = vsew_q;
                vs1_o     = vs1_q;
                vs2_o     = vs2_q;
                if (unit_done_i) begin
                    res_d   = unit_vd_i & keep_mask;
                    state_d = S_GAP;
                end else if (wdog_q == WD_W'(TIMEOUT)) begin
                    // Remaining operand beats are abandoned, not drained.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end

            // One idle cycle so the unit sees vsew 00 between beats.
            S_GAP: state_d = S_OUT;

            S_OUT: begin
                res_valid_o = 1'b1;
                res_data_o  = res_q;
                if (res_ready_i) begin
                    idx_d   = idx_q + epb;
                    state_d = last_beat ? S_DONE : S_FETCH;
                end
            end

            S_DONE: begin
                cmd_done_o = 1'b1;
                cmd_err_o  = err_q;
                err_d      = 1'b0;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge.
    // NOTE: the 128-bit operand/result registers are reset too; they are few
    // flops compared with the guarantee that nothing stale leaks after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            sub_q   <= 1'b0;
            vsew_q  <= 2'b00;
            vl_q    <= '0;
            idx_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            vsew_q  <= vsew_d;
            vl_q    <= vl_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            res_q   <= res_d;
        end
    end

endmodule
